// File: rtl/fsk_frame_deserializer_if.sv
// ---------------------------------------------------------------------------
// fsk_frame_deserializer_if
//
// Bundles the bit-stream input and the word/status outputs of the FSK frame
// deserializer.
//
//   bit_in      demodulated bit, meaningful only while bit_en=1
//   bit_en      one-cycle bit strobe from the bit timing stage
//   word_out    last assembled 16-bit data word, MSB = first received bit
//   word_valid  one-cycle pulse, word_out updated this cycle
//   frame_start one-cycle pulse, sync word accepted
//   locked      high while the deserializer is framed (DATA or CHECK)
//   sync_lost   one-cycle pulse, sync mismatch at a frame boundary
//   parity_err  parity failure flag, qualified by word_valid
//
// Modports:
//   master - bit-stream source / word consumer side
//   slave  - the deserializer itself
// ---------------------------------------------------------------------------
interface fsk_frame_deserializer_if;
    logic        bit_in;
    logic        bit_en;
    logic [15:0] word_out;
    logic        word_valid;
    logic        frame_start;
    logic        locked;
    logic        sync_lost;
    logic        parity_err;

    modport master (
        output bit_in,
        output bit_en,
        input  word_out,
        input  word_valid,
        input  frame_start,
        input  locked,
        input  sync_lost,
        input  parity_err
    );

    modport slave (
        input  bit_in,
        input  bit_en,
        output word_out,
        output word_valid,
        output frame_start,
        output locked,
        output sync_lost,
        output parity_err
    );
endinterface

// File: rtl/fsk_frame_deserializer.sv
// ---------------------------------------------------------------------------
// fsk_frame_deserializer
//
// Hunts for a 16-bit sync word in the recovered FSK bit stream, then packs
// the following bits MSB-first into 16-bit data words. After every
// WORDS_PER_FRAME words the next 16 bits must be the sync word again,
// otherwise lock is dropped and hunting restarts.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    fsk_frame_deserializer_if.slave (bit_in/bit_en in, word and
//          status pulses out; all outputs registered)
//
// Parameters:
//   SYNC_WORD        frame sync pattern, compared MSB-first
//   WORDS_PER_FRAME  data words between sync words, 1..255
//
// Build option:
//   FSK_DESER_PARITY_EN  when defined, every data word is followed by an
//                        odd-parity bit, checked into parity_err. When not
//                        defined, words are 16 bits and parity_err is 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// HUNT  | searching the bit stream for SYNC_WORD, not locked
// DATA  | assembling data words of the current frame
// CHECK | collecting 16 bits that must repeat SYNC_WORD
// ---------------------------------------------------------------------------
module fsk_frame_deserializer #(
    parameter logic [15:0] SYNC_WORD       = 16'hEB90,
    parameter int          WORDS_PER_FRAME = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    fsk_frame_deserializer_if.slave bus
);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [7:0] WORDS_LAST    = 8'(WORDS_PER_FRAME);
    localparam logic [4:0] SYNC_LAST_BIT = 5'd15;
`ifdef FSK_DESER_PARITY_EN
    // bit_cnt value when the parity bit (17th bit) arrives
    localparam logic [4:0] DATA_LAST_BIT = 5'd16;
`else
    localparam logic [4:0] DATA_LAST_BIT = 5'd15;
`endif

    logic [1:0]  state_q,       state_d;
    logic [15:0] sreg_q,        sreg_d;
    logic [15:0] dreg_q,        dreg_d;
    logic [4:0]  bit_cnt_q,     bit_cnt_d;
    logic [7:0]  word_cnt_q,    word_cnt_d;
    logic [15:0] word_out_q,    word_out_d;
    logic        word_valid_q,  word_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q,      locked_d;
    logic        sync_lost_q,   sync_lost_d;
    logic        parity_err_q,  parity_err_d;

    logic [15:0] sreg_shift;
    logic [15:0] dreg_shift;
    logic [7:0]  word_cnt_inc;

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        dreg_d        = dreg_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        word_out_d    = word_out_q;
        // pulses default low so they last one cycle even under back-to-back bit_en
        word_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        sync_lost_d   = 1'b0;
        parity_err_d  = 1'b0;

        // post-shift views; the dropped MSB falls off the top of the shift
        sreg_shift   = (sreg_q << 1) | {15'd0, bus.bit_in};
        dreg_shift   = (dreg_q << 1) | {15'd0, bus.bit_in};
        word_cnt_inc = word_cnt_q + 8'd1;

        if (bus.bit_en) begin
            case (state_q)
                ST_HUNT: begin
                    sreg_d = sreg_shift;
                    if (sreg_shift == SYNC_WORD) begin
                        state_d       = ST_DATA;
                        bit_cnt_d     = 5'd0;
                        word_cnt_d    = 8'd0;
                        frame_start_d = 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_cnt_q == DATA_LAST_BIT) begin
                        word_valid_d = 1'b1;
                        bit_cnt_d    = 5'd0;
                        word_cnt_d   = word_cnt_inc;
`ifdef FSK_DESER_PARITY_EN
                        // bit_in is the parity bit: the 17 bits must hold an odd number of ones
                        word_out_d   = dreg_q;
                        parity_err_d = ~(^{dreg_q, bus.bit_in});
`else
                        dreg_d       = dreg_shift;
                        word_out_d   = dreg_shift;
`endif
                        if (word_cnt_inc == WORDS_LAST) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        dreg_d    = dreg_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                ST_CHECK: begin
                    // sreg keeps the received bits on a miss so an overlapping
                    // sync word can still be caught by HUNT on the next bit
                    sreg_d = sreg_shift;
                    if (bit_cnt_q == SYNC_LAST_BIT) begin
                        bit_cnt_d = 5'd0;
                        if (sreg_shift == SYNC_WORD) begin
                            state_d       = ST_DATA;
                            word_cnt_d    = 8'd0;
                            frame_start_d = 1'b1;
                        end else begin
                            state_d     = ST_HUNT;
                            sync_lost_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        locked_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_HUNT;
            sreg_q        <= 16'h0000;
            dreg_q        <= 16'h0000;
            bit_cnt_q     <= 5'd0;
            word_cnt_q    <= 8'd0;
            word_out_q    <= 16'h0000;
            word_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_lost_q   <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            dreg_q        <= dreg_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            word_out_q    <= word_out_d;
            word_valid_q  <= word_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_lost_q   <= sync_lost_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign bus.word_out    = word_out_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.sync_lost   = sync_lost_q;
    assign bus.parity_err  = parity_err_q;

endmodule

// File: tb/tb_fsk_frame_deserializer.sv
`timescale 1ns/1ps
module tb_fsk_frame_deserializer;

    localparam int EV_NONE = -1;
    localparam int EV_WORD = 0;
    localparam int EV_FS   = 1;
    localparam int EV_SL   = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   gap    = 0;
    exp_t exp_q[$];

    fsk_frame_deserializer_if bus();

    fsk_frame_deserializer #(
        .SYNC_WORD      (16'hEB90),
        .WORDS_PER_FRAME(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Drive one bit; the bit is sampled at the next posedge, and any pulse it
    // causes is expected at the negedge right after that posedge.
    task automatic send_bit(input logic b, input int kind, input logic [15:0] data, input logic perr);
        exp_t e;
        @(negedge clk);
        bus.bit_in = b;
        bus.bit_en = 1'b1;
        if (kind != EV_NONE) begin
            e.kind = kind;
            e.data = data;
            e.perr = perr;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.bit_en = 1'b0;
        end
    endtask

    task automatic send16(input logic [15:0] v, input int kind, input logic [15:0] data, input logic perr);
        for (int i = 15; i >= 1; i--) send_bit(v[i], EV_NONE, 16'h0, 1'b0);
        send_bit(v[0], kind, data, perr);
    endtask

    task automatic send_sync(input int kind);
        send16(16'hEB90, kind, 16'h0, 1'b0);
    endtask

    task automatic send_word(input logic [15:0] w);
`ifdef FSK_DESER_PARITY_EN
        send16(w, EV_NONE, 16'h0, 1'b0);
        send_bit(~(^w), EV_WORD, w, 1'b0);
`else
        send16(w, EV_WORD, w, 1'b0);
`endif
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        bus.bit_en = 1'b0;
        repeat (4) @(negedge clk);
        check_val(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.bit_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_word_out"},    bus.word_out,    16'h0000);
        check_val({tag, "_word_valid"},  bus.word_valid,  0);
        check_val({tag, "_frame_start"}, bus.frame_start, 0);
        check_val({tag, "_locked"},      bus.locked,      0);
        check_val({tag, "_sync_lost"},   bus.sync_lost,   0);
        check_val({tag, "_parity_err"},  bus.parity_err,  0);
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event_timing: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.cyc);
            return;
        end
        case (kind)
            EV_WORD: begin
                check_val("word_out", bus.word_out, e.data);
                check_val("parity_err", bus.parity_err, e.perr);
            end
            EV_FS:   check_val("locked_at_frame_start", bus.locked, 1);
            EV_SL:   check_val("locked_at_sync_lost", bus.locked, 0);
            default: ;
        endcase
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (bus.frame_start) check_event(EV_FS);
            if (bus.word_valid)  check_event(EV_WORD);
            if (bus.sync_lost)   check_event(EV_SL);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] partial;
        bus.bit_in = 1'b0;
        bus.bit_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // sync acquisition after unrelated bits
        gap = 0;
        send16(16'h5A3C, EV_NONE, 16'h0, 1'b0);
        send_sync(EV_FS);
        send_word(16'h1234);
        drain("acq_drained");
        check_val("acq_locked", bus.locked, 1);

        // near-miss sync patterns must not lock
        apply_reset();
        send16(16'hEB91, EV_NONE, 16'h0, 1'b0);
        send16(16'h6B90, EV_NONE, 16'h0, 1'b0);
        drain("false_sync_drained");
        check_val("false_sync_locked", bus.locked, 0);

        // two full frames with bit_en every cycle
        apply_reset();
        send_sync(EV_FS);
        for (int i = 1; i <= 8; i++) send_word(16'(i));
        send_sync(EV_FS);
        for (int i = 8'h11; i <= 8'h18; i++) send_word(16'(i));

        // sync miss at the frame boundary, then junk, then reacquisition
        send16(16'hFFFF, EV_SL, 16'h0, 1'b0);
        send16(16'h1234, EV_NONE, 16'h0, 1'b0);
        send16(16'h5678, EV_NONE, 16'h0, 1'b0);
        drain("miss_drained");
        check_val("miss_locked", bus.locked, 0);
        check_val("miss_word_held", bus.word_out, 16'h0018);
        send_sync(EV_FS);
        send_word(16'h00AA);
        drain("relock_drained");
        check_val("relock_locked", bus.locked, 1);

        // sparse strobe with reset in the middle of word 3
        apply_reset();
        gap = 4;
        send_sync(EV_FS);
        send_word(16'h0A01);
        send_word(16'h0A02);
        partial = 16'h0A03;
        for (int i = 15; i >= 7; i--) send_bit(partial[i], EV_NONE, 16'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset_held");
        reset = 1'b1;
        check_val("midreset_queue", exp_q.size(), 0);
        send_sync(EV_FS);
        send_word(16'h0A03);
        drain("sparse_drained");
        gap = 0;

`ifdef FSK_DESER_PARITY_EN
        // correct then incorrect parity on the same data word
        apply_reset();
        send_sync(EV_FS);
        send16(16'h0003, EV_NONE, 16'h0, 1'b0);
        send_bit(1'b1, EV_WORD, 16'h0003, 1'b0);
        send16(16'h0003, EV_NONE, 16'h0, 1'b0);
        send_bit(1'b0, EV_WORD, 16'h0003, 1'b1);
        drain("parity_drained");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
